// File: rtl/multiplier_arbiter_if.sv
// Two-requester operand/result handshake bundle for multiplier_arbiter.
// master drives operands and result-ready; slave is the arbiter side.
interface multiplier_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        res0_valid;
  logic        res0_ready;
  logic [63:0] res0_r;
  logic        res1_valid;
  logic        res1_ready;
  logic [63:0] res1_r;

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output res0_ready, res1_ready,
    input  req0_ready, req1_ready, res0_valid, res0_r, res1_valid, res1_r
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  res0_ready, res1_ready,
    output req0_ready, req1_ready, res0_valid, res0_r, res1_valid, res1_r
  );
endinterface

// File: rtl/multiplier_arbiter.sv
// Round-robin arbiter sharing one 2-stage 32x32 multiplier between two requesters,
// with credit-managed per-requester result FIFOs. Define MULT_ARB_STATS_EN for stat_issued.
module multiplier_pipelined (
  input  logic        clk,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] p
);
  logic [31:0] a_q;
  logic [31:0] b_q;

  always_ff @(posedge clk) begin
    a_q <= a;
    b_q <= b;
    p   <= {32'b0, a_q} * {32'b0, b_q};
  end
endmodule

module multiplier_arbiter #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multiplier_arbiter_if.slave  bus
`ifdef MULT_ARB_STATS_EN
  ,
  output logic [15:0]          stat_issued
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [1:0]    in_valid;
  logic [1:0]    out_ready;
  logic [1:0]    out_valid;
  logic [63:0]   out_r   [2];
  logic [CW-1:0] occ     [2];
  logic [1:0]    inflight [2];
  logic [CW-1:0] credit  [2];
  logic [1:0]    elig;
  logic [1:0]    grant;
  logic          xfer;
  logic          xfer_tag;
  logic          last;
  logic [1:0]    vld;
  logic [1:0]    tag;
  logic [1:0]    wr;
  logic [31:0]   mul_a;
  logic [31:0]   mul_b;
  logic [63:0]   prod;

  assign in_valid  = {bus.req1_valid, bus.req0_valid};
  assign out_ready = {bus.res1_ready, bus.res0_ready};

  // Grant only requesters with free credit; ties go to whoever was not served last.
  always_comb begin
    elig[0] = in_valid[0] && (credit[0] != '0);
    elig[1] = in_valid[1] && (credit[1] != '0);
    grant   = 2'b00;
    if (rst_n) begin
      if (elig == 2'b11) grant = last ? 2'b01 : 2'b10;
      else               grant = elig;
    end
  end

  assign xfer     = |grant;
  assign xfer_tag = grant[1];
  assign mul_a    = xfer_tag ? bus.req1_a : bus.req0_a;
  assign mul_b    = xfer_tag ? bus.req1_b : bus.req0_b;

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];

  multiplier_pipelined u_mul (
    .clk (clk),
    .a   (mul_a),
    .b   (mul_b),
    .p   (prod)
  );

  // The valid/tag shadow of the multiplier is the only thing that qualifies FIFO writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 2'b00;
      tag  <= 2'b00;
      last <= 1'b1;
    end else begin
      vld <= {vld[0], xfer};
      tag <= {tag[0], xfer_tag};
      if (xfer) last <= xfer_tag;
    end
  end

  for (genvar n = 0; n < 2; n++) begin : g_fifo
    logic [63:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [CW-1:0] cnt;
    logic          hv;
    logic [63:0]   hr;
    logic          pop;
    logic          load;
    logic          take_mem;
    logic          bypass;
    logic          push_mem;

    assign wr[n]       = vld[1] && (tag[1] == 1'(n));
    assign inflight[n] = {1'b0, vld[0] && (tag[0] == 1'(n))}
                       + {1'b0, vld[1] && (tag[1] == 1'(n))};
    assign occ[n]      = cnt + CW'(hv);
    assign credit[n]   = CW'(FIFO_DEPTH) - occ[n] - CW'(inflight[n]);
    assign out_valid[n] = hv;
    assign out_r[n]     = hr;

    // Head register refills from storage first, else straight from the multiplier.
    always_comb begin
      pop      = hv && out_ready[n];
      load     = !hv || pop;
      take_mem = load && (cnt != '0);
      bypass   = load && (cnt == '0) && wr[n];
      push_mem = wr[n] && !bypass;
    end

    always_ff @(posedge clk) begin
      if (push_mem) mem[wp] <= prod;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
        hv  <= 1'b0;
        hr  <= '0;
      end else begin
        if (push_mem) wp <= (wp == PW'(FIFO_DEPTH - 1)) ? '0 : wp + 1'b1;
        if (take_mem) rp <= (rp == PW'(FIFO_DEPTH - 1)) ? '0 : rp + 1'b1;
        case ({push_mem, take_mem})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
        if (take_mem) begin
          hv <= 1'b1;
          hr <= mem[rp];
        end else if (bypass) begin
          hv <= 1'b1;
          hr <= prod;
        end else if (load) begin
          hv <= 1'b0;
        end
      end
    end
  end

  assign bus.res0_valid = out_valid[0];
  assign bus.res0_r     = out_r[0];
  assign bus.res1_valid = out_valid[1];
  assign bus.res1_r     = out_r[1];

`ifdef MULT_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              stat_issued <= '0;
    else if (xfer && stat_issued != 16'hFFFF) stat_issued <= stat_issued + 1'b1;
  end
`endif
endmodule

// File: tb/tb_multiplier_arbiter.sv
// Directed bench for multiplier_arbiter (FIFO_DEPTH=2): table of single ops plus
// contention, backpressure and mid-operation reset sequences.
module tb_multiplier_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multiplier_arbiter_if bus ();

`ifdef MULT_ARB_STATS_EN
  logic [15:0] stat_issued;
`endif

  multiplier_arbiter #(.FIFO_DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus)
`ifdef MULT_ARB_STATS_EN
    ,
    .stat_issued (stat_issued)
`endif
  );

  typedef struct {
    logic        req;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t vecs [8];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic n, input logic v, input logic [31:0] a, input logic [31:0] b);
    if (n) begin
      bus.req1_valid = v;
      bus.req1_a     = a;
      bus.req1_b     = b;
    end else begin
      bus.req0_valid = v;
      bus.req0_a     = a;
      bus.req0_b     = b;
    end
  endtask

  function automatic logic req_ready(input logic n);
    return n ? bus.req1_ready : bus.req0_ready;
  endfunction

  function automatic logic res_valid(input logic n);
    return n ? bus.res1_valid : bus.res0_valid;
  endfunction

  function automatic logic [63:0] res_r(input logic n);
    return n ? bus.res1_r : bus.res0_r;
  endfunction

  task automatic pulse_reset();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  // Issue one op in cycle t; result must appear exactly in cycle t+3 and pop.
  task automatic run_vector(input vec_t v, input int idx);
    apply_stimulus(v.req, 1'b1, v.a, v.b);
    @(negedge clk);
    check_output($sformatf("v%0d_ready", idx), 64'(req_ready(v.req)), 64'd1);
    next_cycle();
    apply_stimulus(v.req, 1'b0, 32'd0, 32'd0);
    next_cycle();
    @(negedge clk);
    check_output($sformatf("v%0d_early_valid", idx), 64'(res_valid(v.req)), 64'd0);
    next_cycle();
    @(negedge clk);
    check_output($sformatf("v%0d_valid", idx), 64'(res_valid(v.req)), 64'd1);
    check_output($sformatf("v%0d_product", idx), res_r(v.req), v.p);
    next_cycle();
    @(negedge clk);
    check_output($sformatf("v%0d_popped", idx), 64'(res_valid(v.req)), 64'd0);
    next_cycle();
  endtask

  initial begin
    int xfers;
    int seen;
    logic took;

    vecs[0] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
    vecs[1] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
    vecs[2] = '{1'b0, 32'h00000000, 32'h12345678, 64'h0000000000000000};
    vecs[3] = '{1'b1, 32'h00000001, 32'hFFFFFFFF, 64'h00000000FFFFFFFF};
    vecs[4] = '{1'b0, 32'h80000000, 32'h80000000, 64'h4000000000000000};
    vecs[5] = '{1'b1, 32'h00010000, 32'h00010000, 64'h0000000100000000};
    vecs[6] = '{1'b0, 32'h0000FFFF, 32'h0000FFFF, 64'h00000000FFFE0001};
    vecs[7] = '{1'b1, 32'hDEADBEEF, 32'h00000002, 64'h00000001BD5B7DDE};

    rst_n = 1'b1;
    apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0);
    apply_stimulus(1'b1, 1'b0, 32'd0, 32'd0);
    bus.res0_ready = 1'b1;
    bus.res1_ready = 1'b1;
    #2 rst_n = 1'b0;

    // Held in reset with both requesters asking: nothing may be accepted or shown.
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_req0_ready", 64'(bus.req0_ready), 64'd0);
    check_output("rst_req1_ready", 64'(bus.req1_ready), 64'd0);
    check_output("rst_res0_valid", 64'(bus.res0_valid), 64'd0);
    check_output("rst_res1_valid", 64'(bus.res1_valid), 64'd0);
    check_output("rst_res0_r", bus.res0_r, 64'd0);
    check_output("rst_res1_r", bus.res1_r, 64'd0);
    next_cycle();
    rst_n = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    next_cycle();

    for (int i = 0; i < 8; i++) run_vector(vecs[i], i);

    // Contention: grants alternate starting with requester 0, one product per cycle.
    pulse_reset();
    apply_stimulus(1'b0, 1'b1, 32'd1, 32'd3);
    apply_stimulus(1'b1, 1'b1, 32'd2, 32'd3);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check_output($sformatf("cont%0d_ready0", k), 64'(bus.req0_ready), 64'((k % 2) == 0));
      check_output($sformatf("cont%0d_ready1", k), 64'(bus.req1_ready), 64'((k % 2) == 1));
      if (k >= 3) begin
        if ((k % 2) == 1) begin
          check_output($sformatf("cont%0d_res0_valid", k), 64'(bus.res0_valid), 64'd1);
          check_output($sformatf("cont%0d_res0_r", k), bus.res0_r, 64'd3);
          check_output($sformatf("cont%0d_res1_idle", k), 64'(bus.res1_valid), 64'd0);
        end else begin
          check_output($sformatf("cont%0d_res1_valid", k), 64'(bus.res1_valid), 64'd1);
          check_output($sformatf("cont%0d_res1_r", k), bus.res1_r, 64'd6);
          check_output($sformatf("cont%0d_res0_idle", k), 64'(bus.res0_valid), 64'd0);
        end
      end
      next_cycle();
    end
    apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0);
    apply_stimulus(1'b1, 1'b0, 32'd0, 32'd0);
    repeat (6) next_cycle();

    // Backpressure on requester 1: credits allow exactly two transfers.
    bus.res1_ready = 1'b0;
    apply_stimulus(1'b1, 1'b1, 32'd10, 32'd2);
    xfers = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      took = bus.req1_ready;
      if (took) xfers++;
      if (k >= 3) begin
        check_output($sformatf("bp%0d_hold_valid", k), 64'(bus.res1_valid), 64'd1);
        check_output($sformatf("bp%0d_hold_r", k), bus.res1_r, 64'd20);
      end
      next_cycle();
      if (took) bus.req1_a = bus.req1_a + 32'd1;
    end
    @(negedge clk);
    check_output("bp_transfers", 64'(xfers), 64'd2);
    check_output("bp_ready_low", 64'(bus.req1_ready), 64'd0);
    next_cycle();
    bus.res1_ready = 1'b1;
    @(negedge clk);
    check_output("bp_drain0_r", bus.res1_r, 64'd20);
    check_output("bp_drain0_ready", 64'(bus.req1_ready), 64'd0);
    next_cycle();
    @(negedge clk);
    check_output("bp_drain1_valid", 64'(bus.res1_valid), 64'd1);
    check_output("bp_drain1_r", bus.res1_r, 64'd22);
    check_output("bp_reissue_ready", 64'(bus.req1_ready), 64'd1);
    next_cycle();
    apply_stimulus(1'b1, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check_output("bp_drained_empty", 64'(bus.res1_valid), 64'd0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_output("bp_reissue_valid", 64'(bus.res1_valid), 64'd1);
    check_output("bp_reissue_r", bus.res1_r, 64'd24);
    repeat (3) next_cycle();

    // Reset while an op is in flight: it must vanish and credits must be whole again.
    apply_stimulus(1'b0, 1'b1, 32'd5, 32'd5);
    @(negedge clk);
    check_output("mid_ready", 64'(bus.req0_ready), 64'd1);
    next_cycle();
    apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0);
    rst_n = 1'b0;
    next_cycle();
    @(negedge clk);
    check_output("mid_rst_valid", 64'(bus.res0_valid), 64'd0);
    next_cycle();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.res0_valid) seen++;
      next_cycle();
    end
    check_output("mid_no_ghost", 64'(seen), 64'd0);
    bus.res0_ready = 1'b0;
    apply_stimulus(1'b0, 1'b1, 32'd7, 32'd7);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_output($sformatf("mid_credit%0d", k), 64'(bus.req0_ready), 64'(k < 2));
      next_cycle();
    end
    apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check_output("mid_post_valid", 64'(bus.res0_valid), 64'd1);
    check_output("mid_post_r", bus.res0_r, 64'd49);
    next_cycle();
    bus.res0_ready = 1'b1;
    repeat (6) next_cycle();

`ifdef MULT_ARB_STATS_EN
    pulse_reset();
    @(negedge clk);
    check_output("stat_reset", 64'(stat_issued), 64'd0);
    next_cycle();
    apply_stimulus(1'b0, 1'b1, 32'd1, 32'd1);
    apply_stimulus(1'b1, 1'b1, 32'd1, 32'd1);
    repeat (70010) next_cycle();
    @(negedge clk);
    check_output("stat_saturate", 64'(stat_issued), 64'hFFFF);
    apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0);
    apply_stimulus(1'b1, 1'b0, 32'd0, 32'd0);
    next_cycle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
